// File: rtl/alu_seq_pkg.sv
// Shared constants and enumerations for the ALU sequencer and its datapath.
package alu_seq_pkg;
  localparam int DATA_W = 8;
  localparam int RES_W  = 16;

  typedef enum logic [2:0] {
    OP_ADD = 3'b000,
    OP_SUB = 3'b001,
    OP_XOR = 3'b010,
    OP_SHL = 3'b011,
    OP_MUL = 3'b100
  } op_e;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_EXEC = 2'd1,
    ST_MUL  = 2'd2,
    ST_DONE = 2'd3
  } state_e;
endpackage

// File: rtl/alu_seq_datapath.sv
// Combinational datapath: one shared add/sub unit plus XOR and left shifter.
module alu_seq_datapath
  import alu_seq_pkg::*;
(
  input  logic [DATA_W-1:0] x,
  input  logic [DATA_W-1:0] y,
  input  logic              sub,
  output logic [DATA_W-1:0] sum,
  output logic              carry,
  output logic [DATA_W-1:0] xor_out,
  output logic [RES_W-1:0]  shl_out
);
  logic [DATA_W:0] raw;

  always_comb begin
    // Subtraction as x + ~y + 1; a missing carry-out means a borrow occurred.
    raw     = {1'b0, x} + {1'b0, (sub ? ~y : y)} + {{DATA_W{1'b0}}, sub};
    sum     = raw[DATA_W-1:0];
    carry   = sub ? ~raw[DATA_W] : raw[DATA_W];
    xor_out = x ^ y;
    shl_out = {{(RES_W-DATA_W){1'b0}}, x} << y[2:0];
  end
endmodule

// File: rtl/alu_sequencer.sv
// Command/response ALU sequencer: single-cycle ADD/SUB/XOR/SHL and an
// 8-iteration shift-add MUL that reuses the one shared adder.
module alu_sequencer
  import alu_seq_pkg::*;
#(
  parameter int MUL_EN = 1
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              cmd_valid,
  output logic              cmd_ready,
  input  logic [2:0]        cmd_op,
  input  logic [DATA_W-1:0] cmd_a,
  input  logic [DATA_W-1:0] cmd_b,
  output logic              rsp_valid,
  input  logic              rsp_ready,
  output logic [RES_W-1:0]  rsp_result,
  output logic              rsp_flag,
  output logic              rsp_err,
  output logic              busy
);
  state_e            state_q, state_d;
  logic              live_q, live_d;
  logic [2:0]        op_q, op_d;
  logic [DATA_W-1:0] a_q, a_d, b_q, b_d, acc_q, acc_d;
  logic [2:0]        cnt_q, cnt_d;
  logic [RES_W-1:0]  res_q, res_d;
  logic              flag_q, flag_d, err_q, err_d;

  logic              illegal;
  logic [DATA_W-1:0] dp_x, dp_y, dp_sum, dp_xor;
  logic              dp_sub, dp_carry;
  logic [RES_W-1:0]  dp_shl;

  assign cmd_ready  = live_q && (state_q == ST_IDLE);
  assign busy       = (state_q != ST_IDLE);
  assign rsp_valid  = (state_q == ST_DONE);
  assign rsp_result = res_q;
  assign rsp_flag   = flag_q;
  assign rsp_err    = err_q;

  assign illegal = (cmd_op > 3'b100) || ((cmd_op == OP_MUL) && (MUL_EN == 0));

  // In MUL the adder accumulates the multiplicand whenever the multiplier LSB is set.
  always_comb begin
    dp_x   = a_q;
    dp_y   = b_q;
    dp_sub = (state_q == ST_EXEC) && (op_q == OP_SUB);
    if (state_q == ST_MUL) begin
      dp_x = acc_q;
      dp_y = b_q[0] ? a_q : '0;
    end
  end

  alu_seq_datapath u_dp (
    .x       (dp_x),
    .y       (dp_y),
    .sub     (dp_sub),
    .sum     (dp_sum),
    .carry   (dp_carry),
    .xor_out (dp_xor),
    .shl_out (dp_shl)
  );

  always_comb begin
    state_d = state_q;
    live_d  = 1'b1;
    op_d    = op_q;
    a_d     = a_q;
    b_d     = b_q;
    acc_d   = acc_q;
    cnt_d   = cnt_q;
    res_d   = res_q;
    flag_d  = flag_q;
    err_d   = err_q;
    case (state_q)
      ST_IDLE: begin
        if (cmd_valid && cmd_ready) begin
          op_d   = cmd_op;
          a_d    = cmd_a;
          b_d    = cmd_b;
          acc_d  = '0;
          cnt_d  = '0;
          res_d  = '0;
          flag_d = 1'b0;
          err_d  = illegal;
          if (illegal)                state_d = ST_DONE;
          else if (cmd_op == OP_MUL)  state_d = ST_MUL;
          else                        state_d = ST_EXEC;
        end
      end
      ST_EXEC: begin
        state_d = ST_DONE;
        case (op_q)
          OP_ADD, OP_SUB: begin
            res_d  = {{(RES_W-DATA_W){1'b0}}, dp_sum};
            flag_d = dp_carry;
          end
          OP_XOR:  res_d = {{(RES_W-DATA_W){1'b0}}, dp_xor};
          default: res_d = dp_shl;
        endcase
      end
      ST_MUL: begin
        // {acc, b} shifts right each step; the product fills it after 8 steps.
        acc_d = {dp_carry, dp_sum[DATA_W-1:1]};
        b_d   = {dp_sum[0], b_q[DATA_W-1:1]};
        cnt_d = cnt_q + 3'd1;
        if (cnt_q == 3'd7) begin
          state_d = ST_DONE;
          res_d   = {acc_d, b_d};
        end
      end
      ST_DONE: begin
        if (rsp_ready) state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= ST_IDLE;
      live_q  <= 1'b0;
      op_q    <= '0;
      a_q     <= '0;
      b_q     <= '0;
      acc_q   <= '0;
      cnt_q   <= '0;
      res_q   <= '0;
      flag_q  <= 1'b0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      live_q  <= live_d;
      op_q    <= op_d;
      a_q     <= a_d;
      b_q     <= b_d;
      acc_q   <= acc_d;
      cnt_q   <= cnt_d;
      res_q   <= res_d;
      flag_q  <= flag_d;
      err_q   <= err_d;
    end
  end
endmodule

// File: tb/tb_alu_sequencer.sv
// Scoreboard bench for alu_sequencer: directed commands push expected responses,
// a negedge monitor pops and compares them as the DUT presents results.
module tb_alu_sequencer;
  logic        clk;
  logic        rst_n;
  logic        cmd_valid, cmd_ready;
  logic [2:0]  cmd_op;
  logic [7:0]  cmd_a, cmd_b;
  logic        rsp_valid, rsp_ready;
  logic [15:0] rsp_result;
  logic        rsp_flag, rsp_err, busy;

  logic        c0_valid, c0_ready;
  logic [2:0]  c0_op;
  logic [7:0]  c0_a, c0_b;
  logic        r0_valid, r0_ready;
  logic [15:0] r0_result;
  logic        r0_flag, r0_err, busy0;

  alu_sequencer #(.MUL_EN(1)) dut (
    .clk(clk), .rst_n(rst_n),
    .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_op(cmd_op),
    .cmd_a(cmd_a), .cmd_b(cmd_b),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_result(rsp_result),
    .rsp_flag(rsp_flag), .rsp_err(rsp_err), .busy(busy)
  );

  alu_sequencer #(.MUL_EN(0)) dut_nomul (
    .clk(clk), .rst_n(rst_n),
    .cmd_valid(c0_valid), .cmd_ready(c0_ready), .cmd_op(c0_op),
    .cmd_a(c0_a), .cmd_b(c0_b),
    .rsp_valid(r0_valid), .rsp_ready(r0_ready), .rsp_result(r0_result),
    .rsp_flag(r0_flag), .rsp_err(r0_err), .busy(busy0)
  );

  typedef struct {
    logic [15:0] res;
    logic        flag;
    logic        err;
    int          lat;
    int          edge_k;
  } exp_t;

  exp_t sb[$];
  exp_t mon_e;
  int   n_total = 0;
  int   n_pass  = 0;
  int   edge_cnt = 0;
  bit   in_resp = 0;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(posedge clk) edge_cnt <= edge_cnt + 1;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_total++;
    if (act !== exp) $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    else n_pass++;
  endtask

  always @(negedge clk) begin
    if (!rst_n) begin
      in_resp = 0;
    end else if (rsp_valid) begin
      if (!in_resp) begin
        in_resp = 1;
        if (sb.size() == 0) chk("unexpected_rsp", 1, 0);
        else if (sb[0].lat >= 0) chk("latency", edge_cnt - sb[0].edge_k, sb[0].lat);
      end
      if (rsp_ready) begin
        in_resp = 0;
        if (sb.size() > 0) begin
          mon_e = sb.pop_front();
          chk("rsp_result", rsp_result, mon_e.res);
          chk("rsp_flag", rsp_flag, mon_e.flag);
          chk("rsp_err", rsp_err, mon_e.err);
        end
      end
    end
  end

  task automatic issue(input logic [2:0] op, input logic [7:0] a, input logic [7:0] b,
                       input logic [15:0] res, input logic fl, input logic er,
                       input int lat, input int hold);
    int n = 0;
    @(negedge clk);
    while (!cmd_ready && n < 100) begin
      @(negedge clk);
      n++;
    end
    if (!cmd_ready) begin
      chk("cmd_ready_timeout", 0, 1);
      return;
    end
    cmd_valid = 1'b1;
    cmd_op    = op;
    cmd_a     = a;
    cmd_b     = b;
    @(posedge clk);
    #1;
    sb.push_back('{res, fl, er, lat, edge_cnt});
    if (hold == 0) begin
      cmd_valid = 1'b0;
    end else begin
      cmd_op = 3'b000;
      for (int i = 0; i < hold; i++) begin
        @(negedge clk);
        chk("cmd_ready_low_while_busy", cmd_ready, 0);
      end
      cmd_valid = 1'b0;
    end
  endtask

  task automatic drain();
    int n = 0;
    while (sb.size() != 0 && n < 200) begin
      @(negedge clk);
      n++;
    end
    if (sb.size() != 0) chk("drain_timeout", sb.size(), 0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  initial begin
    bit seen;
    rst_n = 1'b0;
    cmd_valid = 1'b0; cmd_op = 3'b000; cmd_a = 8'h00; cmd_b = 8'h00;
    rsp_ready = 1'b1;
    c0_valid = 1'b0; c0_op = 3'b000; c0_a = 8'h00; c0_b = 8'h00;
    r0_ready = 1'b0;

    repeat (2) @(negedge clk);
    chk("reset_cmd_ready", cmd_ready, 0);
    chk("reset_rsp_valid", rsp_valid, 0);
    chk("reset_rsp_result", rsp_result, 0);
    chk("reset_rsp_flag", rsp_flag, 0);
    chk("reset_rsp_err", rsp_err, 0);
    chk("reset_busy", busy, 0);
    rst_n = 1'b1;
    #1 chk("cmd_ready_before_first_edge", cmd_ready, 0);
    @(negedge clk);
    chk("cmd_ready_after_first_edge", cmd_ready, 1);

    issue(3'b000, 8'hFF, 8'h01, 16'h0000, 1'b1, 1'b0, 1, 0);
    issue(3'b001, 8'h00, 8'h01, 16'h00FF, 1'b1, 1'b0, 1, 0);
    issue(3'b011, 8'h81, 8'h0F, 16'h4080, 1'b0, 1'b0, 1, 0);
    issue(3'b000, 8'h10, 8'h20, 16'h0030, 1'b0, 1'b0, 1, 0);
    issue(3'b001, 8'h05, 8'h03, 16'h0002, 1'b0, 1'b0, 1, 0);
    issue(3'b010, 8'h3C, 8'h0F, 16'h0033, 1'b0, 1'b0, 1, 0);
    issue(3'b011, 8'h01, 8'hFB, 16'h0008, 1'b0, 1'b0, 1, 0);
    issue(3'b100, 8'hFF, 8'hFF, 16'hFE01, 1'b0, 1'b0, 8, 9);
    issue(3'b100, 8'h0D, 8'h0B, 16'h008F, 1'b0, 1'b0, 8, 0);
    issue(3'b100, 8'h00, 8'h55, 16'h0000, 1'b0, 1'b0, 8, 0);
    issue(3'b111, 8'h12, 8'h34, 16'h0000, 1'b0, 1'b1, 0, 0);
    issue(3'b101, 8'hFF, 8'hFF, 16'h0000, 1'b0, 1'b1, 0, 0);
    issue(3'b000, 8'h7F, 8'h01, 16'h0080, 1'b0, 1'b0, 1, 0);
    drain();

    // Back-pressure: result must hold while the consumer stalls.
    rsp_ready = 1'b0;
    issue(3'b010, 8'hA5, 8'h5A, 16'h00FF, 1'b0, 1'b0, 1, 0);
    @(negedge clk);
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      chk("bp_rsp_valid", rsp_valid, 1);
      chk("bp_result_stable", rsp_result, 16'h00FF);
      chk("bp_busy", busy, 1);
    end
    @(posedge clk);
    #1 rsp_ready = 1'b1;
    @(posedge clk);
    #1;
    chk("post_hs_rsp_valid", rsp_valid, 0);
    chk("post_hs_cmd_ready", cmd_ready, 1);
    chk("post_hs_busy", busy, 0);
    drain();

    // MUL_EN=0 instance treats MUL as illegal.
    @(negedge clk);
    c0_valid = 1'b1; c0_op = 3'b100; c0_a = 8'h03; c0_b = 8'h04;
    @(posedge clk);
    #1 c0_valid = 1'b0;
    @(negedge clk);
    chk("nomul_rsp_valid", r0_valid, 1);
    chk("nomul_rsp_err", r0_err, 1);
    chk("nomul_rsp_result", r0_result, 0);
    chk("nomul_rsp_flag", r0_flag, 0);
    r0_ready = 1'b1;
    @(posedge clk);
    #1 chk("nomul_after_hs", r0_valid, 0);
    r0_ready = 1'b0;

    // Reset during the fifth MUL iteration discards the command.
    @(negedge clk);
    cmd_valid = 1'b1; cmd_op = 3'b100; cmd_a = 8'h37; cmd_b = 8'h59;
    @(posedge clk);
    #1 cmd_valid = 1'b0;
    repeat (5) @(negedge clk);
    chk("mid_mul_busy", busy, 1);
    rst_n = 1'b0;
    #1;
    chk("rst_mid_mul_busy", busy, 0);
    chk("rst_mid_mul_rsp_valid", rsp_valid, 0);
    chk("rst_mid_mul_cmd_ready", cmd_ready, 0);
    chk("rst_mid_mul_result", rsp_result, 0);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    seen = 0;
    repeat (12) begin
      @(negedge clk);
      if (rsp_valid) seen = 1;
    end
    chk("no_rsp_after_reset", seen, 0);
    issue(3'b000, 8'h02, 8'h03, 16'h0005, 1'b0, 1'b0, 1, 0);
    drain();

    repeat (3) @(negedge clk);
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end
endmodule
